display_scan_ctrl: RTL and testbench

Sequencing controller for the three-digit 7-segment output of the calculator. Accepts a signed-magnitude result on a load strobe and converts the magnitude to BCD with a sequential shift-add-3 engine. Holds the converted digits and time-multiplexes them onto the shared deco7seg decoder: it drives the digit value, tens digit, sign flag and digit index, plus active-low anode enables. Sits between the ALU result register and the single deco7seg instance.

---
 rtl/display_scan_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Three-digit 7-segment sequencer: sequential binary-to-BCD conversion plus digit scan.
// Optional anode blanking guard at each digit switch enabled by defining BLANK_GUARD_EN.
module display_scan_ctrl #(
    parameter int SCAN_DIV  = 16667,
    parameter int GUARD_CYC = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [6:0] value,
    input  logic       neg,
    output logic       busy,
    output logic       ovf,
    output logic [1:0] digit_idx,
    output logic [3:0] bcd_digit,
    output logic [3:0] bcd_tens,
    output logic       neg_out,
    output logic [2:0] an_n
);

    if (SCAN_DIV < 2 || SCAN_DIV > 65535 || GUARD_CYC >= SCAN_DIV) begin : g_param_err
        $error("display_scan_ctrl: illegal SCAN_DIV/GUARD_CYC");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_COMMIT} state_t;

    localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [6:0]  shift_q, shift_d;
    logic [11:0] scratch_q, scratch_d;
    logic        neg_pend_q, neg_pend_d;
    logic        busy_q, busy_d;
    logic        ovf_q, ovf_d;
    logic        neg_q, neg_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  units_q, units_d;
    logic [3:0]  digit_q, digit_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  an_q, an_d;
    logic [15:0] presc_q, presc_d;
    logic        wrap;

`ifdef BLANK_GUARD_EN
    localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYC - 1);
    localparam logic [2:0]  AN_RST     = 3'b111;
    logic [15:0] guard_q, guard_d;
`else
    localparam logic [2:0]  AN_RST     = 3'b110;
`endif

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    // One double-dabble iteration over {hundreds, tens, units, binary}.
    function automatic logic [18:0] dabble_step(input logic [11:0] bcd, input logic [6:0] bin);
        return {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0]), bin} << 1;
    endfunction

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        neg_pend_d = neg_pend_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q;
        neg_d      = neg_q;
        tens_d     = tens_q;
        units_d    = units_q;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    shift_d    = value;
                    neg_pend_d = neg;
                    scratch_d  = '0;
                    step_d     = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                {scratch_d, shift_d} = dabble_step(scratch_q, shift_q);
                step_d = step_q + 3'd1;
                if (step_q == 3'd6) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (scratch_q[11:8] != 4'd0) begin
                    ovf_d   = 1'b1;
                    tens_d  = 4'd9;
                    units_d = 4'd9;
                end else begin
                    ovf_d   = 1'b0;
                    tens_d  = scratch_q[7:4];
                    units_d = scratch_q[3:0];
                end
                neg_d   = neg_pend_q;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Scan runs free of the conversion FSM.
        wrap    = (presc_q == PRESC_LAST);
        presc_d = wrap ? 16'd0 : presc_q + 16'd1;
        idx_d   = idx_q;
        if (wrap) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;

`ifdef BLANK_GUARD_EN
        guard_d = guard_q;
        if (wrap) begin
            guard_d = GUARD_LAST;
            an_d    = 3'b111;
        end else if (guard_q != 16'd0) begin
            guard_d = guard_q - 16'd1;
            an_d    = 3'b111;
        end else begin
            an_d    = ~(3'b001 << idx_q);
        end
`else
        an_d = ~(3'b001 << idx_d);
`endif

        case (idx_d)
            2'd2:    digit_d = units_d;
            2'd1:    digit_d = tens_d;
            default: digit_d = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            tens_q  <= '0;
            units_q <= '0;
            digit_q <= '0;
            idx_q   <= '0;
            an_q    <= AN_RST;
            presc_q <= '0;
`ifdef BLANK_GUARD_EN
            guard_q <= GUARD_LAST;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            neg_q   <= neg_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            digit_q <= digit_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            presc_q <= presc_d;
`ifdef BLANK_GUARD_EN
            guard_q <= guard_d;
`endif
        end
    end

    // Conversion scratch is only meaningful while the FSM owns it.
    always_ff @(posedge clk) begin
        shift_q    <= shift_d;
        scratch_q  <= scratch_d;
        neg_pend_q <= neg_pend_d;
    end

    assign busy      = busy_q;
    assign ovf       = ovf_q;
    assign digit_idx = idx_q;
    assign bcd_digit = digit_q;
    assign bcd_tens  = tens_q;
    assign neg_out   = neg_q;
    assign an_n      = an_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a cycle-count based reference model.
module tb_display_scan_ctrl;

    localparam int SD = 8;
    localparam int GC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [6:0] value = '0;
    logic       neg = 1'b0;
    logic       busy, ovf, neg_out;
    logic [1:0] digit_idx;
    logic [3:0] bcd_digit, bcd_tens;
    logic [2:0] an_n;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state: edges since reset, cycles left in a conversion, committed result.
    int n_edges = 0;
    int remain = 0;
    int pend_v = 0;
    int pend_neg = 0;
    int m_tens = 0, m_units = 0, m_ovf = 0, m_neg = 0;

    display_scan_ctrl #(.SCAN_DIV(SD), .GUARD_CYC(GC)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .neg(neg),
        .busy(busy), .ovf(ovf), .digit_idx(digit_idx), .bcd_digit(bcd_digit),
        .bcd_tens(bcd_tens), .neg_out(neg_out), .an_n(an_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            n_edges = 0; remain = 0;
            m_tens = 0; m_units = 0; m_ovf = 0; m_neg = 0;
        end else begin
            n_edges++;
            if (remain > 0) begin
                remain--;
                if (remain == 0) begin
                    m_ovf   = (pend_v >= 100) ? 1 : 0;
                    m_tens  = m_ovf ? 9 : pend_v / 10;
                    m_units = m_ovf ? 9 : pend_v % 10;
                    m_neg   = pend_neg;
                end
            end else if (load) begin
                remain   = 8;
                pend_v   = int'(value);
                pend_neg = int'(neg);
            end
        end
    endtask

    task automatic check_all();
        int idx, exp_an, exp_dig;
        idx = (n_edges / SD) % 3;
        exp_an = 7 & ~(1 << idx);
`ifdef BLANK_GUARD_EN
        if ((n_edges % SD) < GC) exp_an = 7;
`endif
        exp_dig = (idx == 2) ? m_units : (idx == 1) ? m_tens : 0;
        chk("busy", int'(busy), (remain != 0) ? 1 : 0);
        chk("ovf", int'(ovf), m_ovf);
        chk("digit_idx", int'(digit_idx), idx);
        chk("an_n", int'(an_n), exp_an);
        chk("bcd_digit", int'(bcd_digit), exp_dig);
        chk("bcd_tens", int'(bcd_tens), m_tens);
        chk("neg_out", int'(neg_out), m_neg);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic do_load(input int v, input int s);
        load = 1'b1;
        value = 7'(v);
        neg = s[0];
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        ticks(3 * SD + 2);

        do_load(57, 0);
        ticks(8);
        chk("tens_57", int'(bcd_tens), 5);
        ticks(3 * SD);

        do_load(8, 1);
        ticks(3 * SD + 8);

        do_load(115, 0);
        ticks(9);
        chk("ovf_115", int'(ovf), 1);
        do_load(42, 0);
        ticks(9);
        chk("ovf_42", int'(ovf), 0);
        chk("tens_42", int'(bcd_tens), 4);

        do_load(63, 0);
        ticks(2);
        do_load(12, 0);
        ticks(4);
        do_load(33, 1);
        do_load(12, 0);
        ticks(9);
        chk("tens_12", int'(bcd_tens), 1);

        do_load(99, 1);
        ticks(3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ticks(3 * SD);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            load  = ($urandom_range(0, 5) == 0);
            value = 7'($urandom_range(0, 127));
            neg   = 1'($urandom_range(0, 1));
            tick();
            rst_n = 1'b1;
        end
        load = 1'b0;
        ticks(10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
